// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side controller for the ALU arithmetic path. Assembles a
//   byte-serial frame (CMD, A LSB-first, B LSB-first), issues one operation
//   to the arithmetic unit, captures its 2*WIDTH-bit result and returns it
//   LSB-first on the transmit path. When the arithmetic unit never answers,
//   a single error byte 0xEE is returned instead.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD  received byte and its one-cycle strobe
//   A, B, ALU_FUN       operands and function (00 add, 01 sub, 10 mul, 11 div)
//   Arith_Enable        one-cycle issue strobe
//   Arith_OUT/Arith_Flag  registered result and its valid flag
//   TX_P_DATA/TX_D_VLD  byte to transmit and its valid
//   TX_BUSY             transmitter not ready (holds the current byte)
//   CTRL_BUSY           high whenever the sequencer is not idle
//
// Optional build macro
//   ALU_DIV_ZERO_CHK_EN  divide by zero is answered with 0xEE without
//                        issuing the operation to the arithmetic unit.

module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         RX_P_DATA,
  input  logic               RX_D_VLD,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [1:0]         ALU_FUN,
  output logic               Arith_Enable,
  input  logic [2*WIDTH-1:0] Arith_OUT,
  input  logic               Arith_Flag,
  output logic [7:0]         TX_P_DATA,
  output logic               TX_D_VLD,
  input  logic               TX_BUSY,
  output logic               CTRL_BUSY
);

  localparam int NB = WIDTH / 8;
  localparam int NR = 2 * NB;
  localparam int CW = $clog2(NR + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT,
    S_SEND
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      byte_cnt;
  logic [CW-1:0]      send_last;
  logic [TW-1:0]      tmo_cnt;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   b_next;
  logic               cmd_ok;
  logic               last_in;
  logic               tmo_hit;
  logic               tx_accept;
  logic               send_done;
  logic               div_zero;

  assign cmd_ok    = (RX_P_DATA[7:2] == 6'b110000);
  assign last_in   = (byte_cnt == CW'(NB - 1));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign tx_accept = (state == S_SEND) && !TX_BUSY;
  assign send_done = tx_accept && (byte_cnt == send_last);

  // B as it will look once the incoming byte is written; lets the
  // divide-by-zero check see the complete operand on the final byte.
  always_comb begin
    b_next = B;
    b_next[{byte_cnt, 3'b000} +: 8] = RX_P_DATA;
  end

`ifdef ALU_DIV_ZERO_CHK_EN
  assign div_zero = (ALU_FUN == 2'b11) && (b_next == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state   = state;
    Arith_Enable = 1'b0;
    TX_D_VLD     = 1'b0;
    TX_P_DATA    = 8'h00;
    CTRL_BUSY    = (state != S_IDLE);
    case (state)
      S_IDLE:  if (RX_D_VLD && cmd_ok) next_state = S_GET_A;
      S_GET_A: if (RX_D_VLD && last_in) next_state = S_GET_B;
      S_GET_B: if (RX_D_VLD && last_in) next_state = div_zero ? S_SEND : S_ISSUE;
      S_ISSUE: begin
        Arith_Enable = 1'b1;
        next_state   = S_WAIT;
      end
      // A late flag in the final wait cycle still wins over the timeout.
      S_WAIT:  if (Arith_Flag || tmo_hit) next_state = S_SEND;
      S_SEND: begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = result[{byte_cnt, 3'b000} +: 8];
        if (send_done) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operand assembly, result capture and byte/timeout counting. byte_cnt is
  // returned to zero on every state exit so each phase starts at byte 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= 2'b00;
      result    <= '0;
      byte_cnt  <= '0;
      send_last <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          if (RX_D_VLD && cmd_ok) ALU_FUN <= RX_P_DATA[1:0];
        end
        S_GET_A: begin
          if (RX_D_VLD) begin
            A[{byte_cnt, 3'b000} +: 8] <= RX_P_DATA;
            byte_cnt <= last_in ? '0 : byte_cnt + CW'(1);
          end
        end
        S_GET_B: begin
          if (RX_D_VLD) begin
            B        <= b_next;
            byte_cnt <= last_in ? '0 : byte_cnt + CW'(1);
            if (last_in && div_zero) begin
              result    <= {{(2*WIDTH-8){1'b0}}, 8'hEE};
              send_last <= '0;
            end
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          if (Arith_Flag) begin
            result    <= Arith_OUT;
            send_last <= CW'(NR - 1);
          end else if (tmo_hit) begin
            result    <= {{(2*WIDTH-8){1'b0}}, 8'hEE};
            send_last <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_SEND: begin
          if (tx_accept) byte_cnt <= send_done ? '0 : byte_cnt + CW'(1);
        end
        default: byte_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer (WIDTH=16, TIMEOUT=8).
//   A small arithmetic-unit model answers Arith_Enable one cycle later.
//   Expected TX bytes and expected issue operands are queued when a frame
//   is driven and compared when the DUT transmits or issues.

module tb_alu_cmd_sequencer;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;

  logic               CLK;
  logic               RST;
  logic [7:0]         RX_P_DATA;
  logic               RX_D_VLD;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [1:0]         ALU_FUN;
  logic               Arith_Enable;
  logic [2*WIDTH-1:0] Arith_OUT;
  logic               Arith_Flag;
  logic [7:0]         TX_P_DATA;
  logic               TX_D_VLD;
  logic               TX_BUSY;
  logic               CTRL_BUSY;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_Enable(Arith_Enable),
    .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CTRL_BUSY(CTRL_BUSY)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  exp_q[$];
  logic [33:0] issue_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          en_cyc = 0;
  int          tx_cyc = 0;
  int          last_b_cyc = 0;
  bit          alu_hang = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // Arithmetic unit model: signed 16-bit operands, 32-bit signed result.
  function automatic logic [31:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] fun);
    logic signed [31:0] xa, xb;
    xa = {{16{a[15]}}, a};
    xb = {{16{b[15]}}, b};
    case (fun)
      2'b00:   return xa + xb;
      2'b01:   return xa - xb;
      2'b10:   return xa * xb;
      default: return (xb == 0) ? 32'hFFFF_FFFF : xa / xb;
    endcase
  endfunction

  always @(posedge CLK) begin
    Arith_Flag <= Arith_Enable && !alu_hang;
    if (Arith_Enable) Arith_OUT <= aluModel(A, B, ALU_FUN);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: compares issues and accepted TX bytes against the scoreboard.
  initial begin
    bit en_prev = 0;
    bit tx_prev = 0;
    forever begin
      @(negedge CLK);
      if (Arith_Enable) begin
        if (en_prev) checkOutput("enable_width", 64'd2, 64'd1);
        if (issue_q.size() == 0) checkOutput("unexpected_enable", 64'd1, 64'd0);
        else checkOutput("issue_operands", {30'd0, A, B, ALU_FUN}, {30'd0, issue_q.pop_front()});
        en_cyc = cyc;
      end
      en_prev = Arith_Enable;
      if (TX_D_VLD && !tx_prev) tx_cyc = cyc;
      tx_prev = TX_D_VLD;
      if (TX_D_VLD && !TX_BUSY) begin
        if (exp_q.size() == 0) checkOutput("unexpected_tx", {56'd0, TX_P_DATA}, 64'hDEAD);
        else checkOutput("tx_byte", {56'd0, TX_P_DATA}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic sendByte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [15:0] a,
                               input logic [15:0] b, input logic [31:0] res,
                               input int nres, input bit issued);
    for (int i = 0; i < nres; i++) exp_q.push_back(res[8*i +: 8]);
    if (issued) issue_q.push_back({a, b, cmd[1:0]});
    sendByte(cmd);
    sendByte(a[7:0]);
    sendByte(a[15:8]);
    sendByte(b[7:0]);
    last_b_cyc = cyc;
    sendByte(b[15:8]);
  endtask

  task automatic waitIdle(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0 && !CTRL_BUSY) begin
        ok = 1;
        break;
      end
    end
    checkOutput(name, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{8'hC0, 16'h0005, 16'h0003, 32'h0000_0008};
    vecs[1] = '{8'hC2, 16'h00FF, 16'h0002, 32'h0000_01FE};
    vecs[2] = '{8'hC1, 16'h0003, 16'h0005, 32'hFFFF_FFFE};
    vecs[3] = '{8'hC0, 16'h7FFF, 16'h0001, 32'h0000_8000};
    vecs[4] = '{8'hC2, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE};
    vecs[5] = '{8'hC3, 16'h0064, 16'h0007, 32'h0000_000E};

    RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; TX_BUSY = 1'b0;
    Arith_Flag = 1'b0; Arith_OUT = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_outputs",
                {20'd0, A, B, ALU_FUN, Arith_Enable, TX_P_DATA, TX_D_VLD, CTRL_BUSY},
                64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    $display("[TB] table-driven frames");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].cmd, vecs[v].a, vecs[v].b, vecs[v].res, 4, 1);
      waitIdle("frame_done");
      checkOutput("issue_latency", 64'(en_cyc - last_b_cyc), 64'd1);
      checkOutput("tx_latency", 64'(tx_cyc - en_cyc), 64'd2);
    end

    $display("[TB] invalid command then valid frame");
    sendByte(8'h55);
    checkOutput("invalid_busy0", {63'd0, CTRL_BUSY}, 64'd0);
    sendByte(8'h05);
    sendByte(8'h00);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("invalid_busy1", {63'd0, CTRL_BUSY}, 64'd0);
    applyStimulus(8'hC0, 16'h0001, 16'h0001, 32'h0000_0002, 4, 1);
    waitIdle("after_invalid_done");

    $display("[TB] back-pressure");
    TX_BUSY = 1'b1;
    applyStimulus(8'hC0, 16'h0005, 16'h0003, 32'h0000_0008, 4, 1);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (TX_D_VLD) begin
          seen = 1;
          break;
        end
        @(posedge CLK); #1;
      end
      checkOutput("bp_tx_seen", {63'd0, seen}, 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      checkOutput("bp_hold", {55'd0, TX_D_VLD, TX_P_DATA}, {55'd1, 8'h08});
    end
    TX_BUSY = 1'b0;
    waitIdle("bp_done");

    $display("[TB] arithmetic timeout");
    alu_hang = 1;
    applyStimulus(8'hC0, 16'h0005, 16'h0003, 32'h0000_00EE, 1, 1);
    waitIdle("timeout_done");
    checkOutput("timeout_latency", 64'(tx_cyc - en_cyc), 64'(TIMEOUT + 1));
    alu_hang = 0;

    $display("[TB] reset mid-frame");
    sendByte(8'hC0);
    sendByte(8'h05);
    checkOutput("midframe_busy", {63'd0, CTRL_BUSY}, 64'd1);
    RST = 1'b0;
    #1;
    checkOutput("midframe_reset",
                {20'd0, A, B, ALU_FUN, Arith_Enable, TX_P_DATA, TX_D_VLD, CTRL_BUSY},
                64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(8'hC1, 16'h0010, 16'h0004, 32'h0000_000C, 4, 1);
    waitIdle("post_reset_done");

    $display("[TB] divide by zero");
`ifdef ALU_DIV_ZERO_CHK_EN
    applyStimulus(8'hC3, 16'h000A, 16'h0000, 32'h0000_00EE, 1, 0);
`else
    applyStimulus(8'hC3, 16'h000A, 16'h0000, 32'hFFFF_FFFF, 4, 1);
`endif
    waitIdle("divzero_done");

    repeat (4) @(posedge CLK);
    #1;
    checkOutput("issue_q_empty", 64'(issue_q.size()), 64'd0);
    checkOutput("final_idle", {63'd0, CTRL_BUSY}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
